// File: rtl/count_ctrl.sv
// Two-digit BCD up/down counter with a cycle prescaler and an IDLE/RUN/PAUSE/DONE control FSM.
// Each count step emits a registered one-cycle tick; done flags that the terminal value was reached.
module count_ctrl #(
    parameter int unsigned DIV  = 50000000,
    parameter logic [7:0]  TERM = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       up_dn,
    output logic       tick,
    output logic [3:0] digit_lo,
    output logic [3:0] digit_hi,
    output logic [1:0] state,
    output logic       done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        FINISH = 2'b11
    } state_t;

    state_t          cur;
    logic [PW-1:0]   presc;
    logic [7:0]      cnt;
    logic            dir;
    logic            step;
    logic            hit;
    logic [7:0]      nxt_cnt;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {((v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {((v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1), 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Step fires on the last prescaler phase; terminal detection looks at the post-step value.
    always_comb begin
        step    = (cur == RUN) && (presc == PW'(DIV - 1));
        nxt_cnt = dir ? bcd_inc(cnt) : bcd_dec(cnt);
        hit     = dir ? (nxt_cnt == TERM) : (nxt_cnt == 8'h00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= IDLE;
            presc <= '0;
            cnt   <= 8'h00;
            dir   <= 1'b1;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                cur   <= IDLE;
                presc <= '0;
                cnt   <= 8'h00;
                done  <= 1'b0;
            end else begin
                unique case (cur)
                    IDLE: begin
                        if (start) begin
                            cur   <= RUN;
                            dir   <= up_dn;
                            presc <= '0;
                            cnt   <= up_dn ? 8'h00 : TERM;
                        end
                    end
                    RUN: begin
                        // A pause arriving on the step edge still takes the step first.
                        presc <= step ? '0 : presc + PW'(1);
                        if (step) begin
                            cnt  <= nxt_cnt;
                            tick <= 1'b1;
                            if (hit) begin
                                cur  <= FINISH;
                                done <= 1'b1;
                            end else if (pause) begin
                                cur <= PAUSED;
                            end
                        end else if (pause) begin
                            cur <= PAUSED;
                        end
                    end
                    PAUSED: begin
                        if (!pause && start)
                            cur <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state    = cur;
    assign digit_lo = cnt[3:0];
    assign digit_hi = cnt[7:4];

endmodule
